pc_fetch_unit: RTL and testbench

Fetch-stage PC sequencer for the RISC-V pipeline: owns the program counter, consumes the redirect request (`pc_sel`/`branch_pc`) produced by the EX-stage branch logic, and drives the instruction-memory address. It buffers a redirect that arrives while fetch is held, detects the halt sentinel target, flags misaligned targets, and issues the IF/ID flush pulse. It sits between the hazard/branch logic and the instruction memory, feeding the IF/ID register.

---
 rtl/pc_fetch_unit.sv | 208 ++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Fetch-stage program-counter sequencer. Owns the PC and drives the
// instruction-memory address. It applies redirects from the EX-stage branch
// logic, holds a redirect that arrives while fetch is stalled, detects the
// halt sentinel target, flags misaligned redirect targets and raises the
// IF/ID flush request.
//
// Parameters
//   WIDTH           PC / instruction-memory address width in bits (>= 3)
//
// Ports
//   clk             in   1      system clock, rising edge
//   reset           in   1      synchronous, active-low reset
//   stall           in   1      hold fetch; PC frozen while high
//   pc_sel          in   1      one-cycle redirect request
//   branch_pc       in   32     redirect target, 32'hFFFFFFFF = halt sentinel
//   pc              out  WIDTH  current fetch address
//   pc_valid        out  1      pc addresses a real instruction this cycle
//   flush_if_id     out  1      kill the wrong-path instruction in IF/ID
//   halted          out  1      fetch stopped until reset
//   misaligned_err  out  1      sticky: a redirect target had nonzero [1:0]
//   fetch_count     out  32     saturating count of accepted fetches
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [31:0]      branch_pc,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             flush_if_id,
    output logic             halted,
    output logic             misaligned_err,
    output logic [31:0]      fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT      = 2'b00,
        ST_RUN       = 2'b01,
        ST_HOLD_PEND = 2'b10,
        ST_HALTED    = 2'b11
    } state_e;

    localparam logic [31:0]      HALT_SENTINEL = 32'hFFFF_FFFF;
    localparam logic [31:0]      COUNT_MAX     = 32'hFFFF_FFFF;
    localparam logic [WIDTH-1:0] PC_ZERO       = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] PC_STEP       = {{(WIDTH-3){1'b0}}, 3'b100};

    // Redirect target: truncate to the address width and force word alignment.
    function automatic logic [WIDTH-1:0] form_target(input logic [31:0] bpc);
        logic [WIDTH-1:0] t;
        t = {bpc[WIDTH-1:2], 2'b00};
        return t;
    endfunction

    // A target is misaligned when either of its two low bits is set.
    function automatic logic is_misaligned(input logic [31:0] bpc);
        logic m;
        m = (bpc[1:0] != 2'b00);
        return m;
    endfunction

    // Saturating increment for the fetch counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        logic [31:0] r;
        if (v != COUNT_MAX) begin
            r = v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             mis_q, mis_d;
    logic [31:0]      count_q, count_d;

    logic             live_s;       // state that reacts to redirects
    logic             halt_req_s;   // halt sentinel seen in a reacting state
    logic             redirect_s;   // ordinary (non-halt) redirect accepted
    logic             valid_s;
    logic [WIDTH-1:0] tgt_s;

    // Decode of the current state and the incoming redirect.
    always_comb begin
        live_s     = (state_q == ST_RUN) || (state_q == ST_HOLD_PEND);
        valid_s    = live_s;
        tgt_s      = form_target(branch_pc);
        halt_req_s = live_s && pc_sel && (branch_pc == HALT_SENTINEL);
        redirect_s = live_s && pc_sel && !halt_req_s;
    end

    // Next-state, next-PC and pending-target logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;

        case (state_q)
            ST_BOOT: begin
                // BOOT lasts one cycle regardless of stall or redirects.
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (halt_req_s) begin
                    state_d = ST_HALTED;
                end else if (pc_sel && stall) begin
                    pend_d  = tgt_s;
                    state_d = ST_HOLD_PEND;
                end else if (pc_sel) begin
                    pc_d = tgt_s;
                end else if (!stall) begin
                    pc_d = pc_q + PC_STEP;   // wraps silently at 2^WIDTH
                end else begin
                    pc_d = pc_q;
                end
            end

            ST_HOLD_PEND: begin
                if (halt_req_s) begin
                    // Halt outranks the buffered redirect.
                    state_d = ST_HALTED;
                    pend_d  = PC_ZERO;
                end else if (!stall) begin
                    // A redirect arriving on the release cycle is the youngest.
                    if (pc_sel) begin
                        pc_d = tgt_s;
                    end else begin
                        pc_d = pend_q;
                    end
                    pend_d  = PC_ZERO;
                    state_d = ST_RUN;
                end else if (pc_sel) begin
                    pend_d = tgt_s;
                end else begin
                    pend_d = pend_q;
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_BOOT;
                pc_d    = PC_ZERO;
                pend_d  = PC_ZERO;
            end
        endcase
    end

    // Sticky misalignment flag and saturating fetch counter.
    always_comb begin
        mis_d   = mis_q;
        count_d = count_q;

        if (redirect_s && is_misaligned(branch_pc)) begin
            mis_d = 1'b1;
        end else begin
            mis_d = mis_q;
        end

        // An instruction is accepted when it is valid, not stalled and not
        // being flushed by a redirect in the same cycle.
        if (valid_s && !stall && !pc_sel) begin
            count_d = sat_inc(count_q);
        end else begin
            count_d = count_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= PC_ZERO;
            pend_q  <= PC_ZERO;
            mis_q   <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            mis_q   <= mis_d;
            count_q <= count_d;
        end
    end

    // Output drive: everything but the flush request comes from registers.
    always_comb begin
        pc             = pc_q;
        pc_valid       = valid_s;
        halted         = (state_q == ST_HALTED);
        misaligned_err = mis_q;
        fetch_count    = count_q;
        // Flush follows pc_sel in any reacting state, stall or halt alike.
        flush_if_id    = pc_sel && live_s;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam int W = 9;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         pc_sel;
    logic [31:0]  branch_pc;
    logic [W-1:0] pc;
    logic         pc_valid;
    logic         flush_if_id;
    logic         halted;
    logic         misaligned_err;
    logic [31:0]  fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_unit #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .pc_sel         (pc_sel),
        .branch_pc      (branch_pc),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .flush_if_id    (flush_if_id),
        .halted         (halted),
        .misaligned_err (misaligned_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic sel, input logic [31:0] bpc);
        stall     = s;
        pc_sel    = sel;
        branch_pc = bpc;
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; pc_sel = 1'b0; branch_pc = 32'd0;
        tick(); tick();
        chk("rst_pc",      32'(pc),             32'h0);
        chk("rst_valid",   32'(pc_valid),       32'h0);
        chk("rst_halted",  32'(halted),         32'h0);
        chk("rst_mis",     32'(misaligned_err), 32'h0);
        chk("rst_count",   fetch_count,         32'h0);
        chk("rst_flush",   32'(flush_if_id),    32'h0);

        // Release reset: BOOT cycle, then sequential fetch.
        reset = 1'b1;
        #1;
        chk("boot_valid",  32'(pc_valid),       32'h0);
        tick();
        chk("run_pc0",     32'(pc),             32'h0);
        chk("run_valid",   32'(pc_valid),       32'h1);
        tick();
        chk("seq_pc4",     32'(pc),             32'h4);
        tick();
        chk("seq_pc8",     32'(pc),             32'h8);
        chk("seq_cnt2",    fetch_count,         32'd2);
        tick(); tick();
        chk("seq_pc10",    32'(pc),             32'h10);
        chk("seq_cnt4",    fetch_count,         32'd4);

        // Unstalled redirect.
        drive(1'b0, 1'b1, 32'h40);
        chk("redir_flush", 32'(flush_if_id),    32'h1);
        tick();
        chk("redir_pc",    32'(pc),             32'h40);
        chk("redir_cnt",   fetch_count,         32'd4);
        chk("redir_mis0",  32'(misaligned_err), 32'h0);

        // Misaligned redirect.
        drive(1'b0, 1'b1, 32'h43);
        tick();
        chk("mis_pc",      32'(pc),             32'h40);
        chk("mis_set",     32'(misaligned_err), 32'h1);
        drive(1'b0, 1'b0, 32'h0);
        chk("noflush",     32'(flush_if_id),    32'h0);
        tick();
        chk("mis_pc44",    32'(pc),             32'h44);
        chk("mis_sticky",  32'(misaligned_err), 32'h1);
        chk("mis_cnt5",    fetch_count,         32'd5);

        // Stalled redirects: youngest wins, one flush per pc_sel.
        drive(1'b1, 1'b1, 32'h20);
        chk("st_flush1",   32'(flush_if_id),    32'h1);
        tick();
        chk("st_hold1",    32'(pc),             32'h44);
        drive(1'b1, 1'b0, 32'h0);
        chk("st_noflush",  32'(flush_if_id),    32'h0);
        tick();
        chk("st_hold2",    32'(pc),             32'h44);
        drive(1'b1, 1'b1, 32'h30);
        chk("st_flush2",   32'(flush_if_id),    32'h1);
        tick();
        chk("st_hold3",    32'(pc),             32'h44);
        chk("st_cnt",      fetch_count,         32'd5);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("st_apply",    32'(pc),             32'h30);
        chk("st_cnt6",     fetch_count,         32'd6);
        tick();
        chk("st_run_pc",   32'(pc),             32'h34);
        chk("st_cnt7",     fetch_count,         32'd7);

        // Wrap at 2^WIDTH and target truncation.
        drive(1'b0, 1'b1, 32'h1FC);
        tick();
        chk("wrap_pre",    32'(pc),             32'h1FC);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_pc",     32'(pc),             32'h0);
        chk("wrap_cnt",    fetch_count,         32'd8);
        drive(1'b0, 1'b1, 32'h0000_0604);
        tick();
        chk("trunc_pc",    32'(pc),             32'h4);

        // Reset in HOLD_PEND drops the pending redirect; BOOT ignores stall.
        drive(1'b1, 1'b1, 32'h80);
        tick();
        chk("hp_pc",       32'(pc),             32'h4);
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0);
        tick();
        chk("hr_pc",       32'(pc),             32'h0);
        chk("hr_valid",    32'(pc_valid),       32'h0);
        chk("hr_mis",      32'(misaligned_err), 32'h0);
        chk("hr_cnt",      fetch_count,         32'h0);
        chk("hr_halted",   32'(halted),         32'h0);
        reset = 1'b1;
        tick();
        chk("boot_stall",  32'(pc_valid),       32'h1);
        chk("boot_pc",     32'(pc),             32'h0);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("hr_nopend",   32'(pc),             32'h4);
        chk("hr_cnt1",     fetch_count,         32'd1);

        // Halt sentinel while stalled with a pending redirect.
        drive(1'b1, 1'b1, 32'h100);
        tick();
        drive(1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("halt_flush",  32'(flush_if_id),    32'h1);
        tick();
        chk("halt_set",    32'(halted),         32'h1);
        chk("halt_valid",  32'(pc_valid),       32'h0);
        chk("halt_pc",     32'(pc),             32'h4);
        chk("halt_nomis",  32'(misaligned_err), 32'h0);
        drive(1'b0, 1'b1, 32'h40);
        chk("halt_noflsh", 32'(flush_if_id),    32'h0);
        tick();
        chk("halt_pc2",    32'(pc),             32'h4);
        chk("halt_keep",   32'(halted),         32'h1);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("halt_pc3",    32'(pc),             32'h4);
        chk("halt_cnt",    fetch_count,         32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
